// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with row synchronizer and scan-level debounce
// Optional feature macro: KEYPAD_HOLD_LAST_EN (key_val keeps the last accepted code after release)
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_val,
    output logic       key_down,
    output logic       key_press
);

    localparam int SW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} state_t;

    state_t        state, state_next;
    logic [3:0]    col_next;
    logic [SW-1:0] slot;
    logic          slot_end;
    logic [3:0]    row_meta, row_sync;
    logic [3:0]    row_low;
    logic [1:0]    hit_row;
    logic          hit;
    logic          scan_hit;
    logic [3:0]    scan_code;
    logic [4:0]    cand, prev_cand, stable;
    logic [DW-1:0] deb, deb_next;

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign slot_end = (slot == SLOT_LAST);

    always_comb begin
        state_next = state;
        col_next   = col;
        if (slot_end) begin
            case (state)
                COL0:    begin state_next = COL1; col_next = 4'b1101; end
                COL1:    begin state_next = COL2; col_next = 4'b1011; end
                COL2:    begin state_next = COL3; col_next = 4'b0111; end
                default: begin state_next = COL0; col_next = 4'b1110; end
            endcase
        end
    end

    // Lowest-index low row wins within the currently driven column
    assign row_low = ~row_sync;
    assign hit     = |row_low;

    always_comb begin
        hit_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_low[i]) hit_row = 2'(i);
        end
    end

    // Candidate encoding: {valid, code}; "none" is all zeros so equality compares stay simple
    always_comb begin
        cand = 5'b0;
        if (scan_hit)  cand = {1'b1, scan_code};
        else if (hit)  cand = {1'b1, map_key(hit_row, state)};
    end

    always_comb begin
        deb_next = DW'(1);
        if (cand == prev_cand) deb_next = (deb == DEB_MAX) ? deb : deb + DW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= COL0;
            col      <= 4'b1110;
            slot     <= '0;
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            state    <= state_next;
            col      <= col_next;
            slot     <= slot_end ? '0 : slot + SW'(1);
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_hit  <= 1'b0;
            scan_code <= 4'h0;
            prev_cand <= 5'b0;
            stable    <= 5'b0;
            deb       <= '0;
            key_val   <= 4'hF;
            key_down  <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (slot_end) begin
                if (state == COL3) begin
                    scan_hit  <= 1'b0;
                    scan_code <= 4'h0;
                    prev_cand <= cand;
                    deb       <= deb_next;
                    if (deb_next == DEB_MAX && cand != stable) begin
                        stable <= cand;
                        if (cand[4]) begin
                            key_val   <= cand[3:0];
                            key_down  <= 1'b1;
                            key_press <= 1'b1;
                        end else begin
                            key_down <= 1'b0;
`ifdef KEYPAD_HOLD_LAST_EN
                            key_val  <= key_val;
`else
                            key_val  <= 4'hF;
`endif
                        end
                    end
                end else begin
                    scan_hit  <= cand[4];
                    scan_code <= cand[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a behavioural keypad model
module tb_keypad_scanner;

    localparam int ST   = 8;
    localparam int DS   = 2;
    localparam int SCAN = 4 * ST;
    localparam int LAT  = 3 * SCAN + 3;
`ifdef KEYPAD_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row, col, key_val;
    logic        key_down, key_press;
    logic [15:0] pressed = 16'h0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_press  = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;

    typedef struct {
        logic [15:0] keys;
        int          cycles;
        logic        exp_down;
        logic [3:0]  exp_val;
        logic        push;
        logic [3:0]  push_code;
    } vec_t;

    vec_t vecs[7];

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_val   (key_val),
        .key_down  (key_down),
        .key_press (key_press)
    );

    // pressed[r*4+c] shorts row r to column c
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && key_press) begin
            n_press++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_press: got key_val %h, expected no pulse (t=%0t)", key_val, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("press_val", {4'h0, key_val}, {4'h0, mon_exp});
                check("press_down", {7'h0, key_down}, 8'h1);
            end
        end
    end

    initial begin
        logic [3:0] exp_col;
        int         p0;
        int         k;

        vecs[0] = '{16'h0020, LAT,      1'b1, 4'h5,                  1'b1, 4'h5};
        vecs[1] = '{16'h0020, 10*SCAN,  1'b1, 4'h5,                  1'b0, 4'h0};
        vecs[2] = '{16'h0000, LAT,      1'b0, HOLD ? 4'h5 : 4'hF,    1'b0, 4'h0};
        vecs[3] = '{16'h0003, LAT,      1'b1, 4'h1,                  1'b1, 4'h1};
        vecs[4] = '{16'h0002, LAT,      1'b1, 4'h2,                  1'b1, 4'h2};
        vecs[5] = '{16'h0000, LAT,      1'b0, HOLD ? 4'h2 : 4'hF,    1'b0, 4'h0};
        vecs[6] = '{16'h2000, LAT,      1'b1, 4'hF,                  1'b1, 4'hF};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (13) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_col",   {4'h0, col},     8'h0E);
        check("rst_val",   {4'h0, key_val}, 8'h0F);
        check("rst_down",  {7'h0, key_down}, 8'h0);
        check("rst_press", {7'h0, key_press}, 8'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i <= 32; i++) begin
            #1;
            exp_col = ~(4'b0001 << ((i / ST) % 4));
            check($sformatf("col_walk%0d", i), {4'h0, col}, {4'h0, exp_col});
            @(negedge clock);
        end

        for (int v = 0; v < 7; v++) begin
            pressed = vecs[v].keys;
            if (vecs[v].push) exp_q.push_back(vecs[v].push_code);
            repeat (vecs[v].cycles) @(negedge clock);
            check($sformatf("vec%0d_down", v), {7'h0, key_down}, {7'h0, vecs[v].exp_down});
            check($sformatf("vec%0d_val", v),  {4'h0, key_val},  {4'h0, vecs[v].exp_val});
        end

        reset = 1'b1;
        #1;
        check("hold_rst_down", {7'h0, key_down}, 8'h0);
        check("hold_rst_col",  {4'h0, col},      8'h0E);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(4'hF);
        k = 0;
        while (!key_down && k < LAT) begin
            @(negedge clock);
            k++;
        end
        check("rearm_down", {7'h0, key_down}, 8'h1);
        check("rearm_val",  {4'h0, key_val},  8'h0F);

        pressed = 16'h0;
        repeat (LAT) @(negedge clock);
        check("rel_f_down", {7'h0, key_down}, 8'h0);

        p0 = n_press;
        for (int b = 0; b < 6; b++) begin
            pressed = 16'h0200;
            repeat (SCAN) @(negedge clock);
            pressed = 16'h0000;
            repeat (SCAN) @(negedge clock);
        end
        repeat (3 * SCAN) @(negedge clock);
        check("bounce_presses", 8'(n_press - p0), 8'h0);
        check("bounce_val",  {4'h0, key_val},  8'h0F);
        check("bounce_down", {7'h0, key_down}, 8'h0);

        check("pending_presses", 8'(exp_q.size()), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
